// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types, default widths and helpers for the FIFO port arbiters
// Purpose: state encoding, default parameter values and the round-robin
//          pointer increment used by the write- and read-side arbiters.
// Ports:   none (package).
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ    = 3;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;
  localparam int DEF_ID_WIDTH   = 2;
  localparam int CNT_WIDTH      = 8;

  // Modulo increment of a requester index: num_req-1 wraps to 0.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_req);
    return (ptr + 32'd1 >= num_req) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer/FIFO write-port bundle for the write arbiter
// Purpose: groups the producer handshake, the FIFO write port and the
//          grant status into one bundle.
// Signals: req_valid/req_last/req_data (producers -> arbiter),
//          req_ready (arbiter -> producers), wfull (FIFO -> arbiter),
//          winc/wdata (arbiter -> FIFO), grant_id/busy (status).
// Modports: slave = arbiter side, master = producers + FIFO side.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ID_WIDTH   = DEF_ID_WIDTH
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          wfull;
  logic                          winc;
  logic [DATA_WIDTH-1:0]         wdata;
  logic [ID_WIDTH-1:0]           grant_id;
  logic                          busy;

  modport slave (
    input  req_valid, req_last, req_data, wfull,
    output req_ready, winc, wdata, grant_id, busy
  );

  modport master (
    output req_valid, req_last, req_data, wfull,
    input  req_ready, winc, wdata, grant_id, busy
  );

endinterface

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin first-set picker
// Purpose: finds the first set bit of req scanning upward from rr_ptr,
//          wrapping modulo NUM_REQ.
// Ports:   req    in  NUM_REQ   request vector
//          rr_ptr in  ID_WIDTH  scan start index (< NUM_REQ)
//          found  out 1         any request set
//          sel    out ID_WIDTH  selected index (0 when none)
module rr_priority_pick #(
  parameter int NUM_REQ  = 3,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic                found,
  output logic [ID_WIDTH-1:0] sel
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;

  // Rotate so that bit 0 of req_rot is requester rr_ptr.
  assign req_dbl = {req, req};
  assign req_rot = NUM_REQ'(req_dbl >> rr_ptr);

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    // Scan from the far end so the lowest rotated offset is the final winner.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (|(req_rot & (NUM_REQ'(1) << k))) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        found = 1'b1;
        sel   = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-locked arbiter for the async FIFO write port
// Purpose: shares winc/wdata among NUM_REQ producers in the wclk domain.
//          A grant is held until the owner's last beat is accepted or
//          MAX_BURST beats have been written; wfull stalls the burst.
// Ports:   wclk    in  1  write-domain clock
//          wrst_n  in  1  asynchronous active-low reset
//          bus     slave  producer handshake, FIFO write port, grant_id, busy
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
  input logic               wclk,
  input logic               wrst_n,
  fifo_wr_arbiter_if.slave  bus
);

  arb_state_t           state, state_nxt;
  logic [ID_WIDTH-1:0]  rr_ptr, rr_ptr_nxt;
  logic [ID_WIDTH-1:0]  grant_id, grant_id_nxt;
  logic [CNT_WIDTH-1:0] beat_cnt, beat_cnt_nxt;

  logic                 pick_found;
  logic [ID_WIDTH-1:0]  pick_id;
  logic [NUM_REQ-1:0]   grant_oh;
  logic                 owner_valid;
  logic                 owner_last;
  logic                 accept;
  logic                 burst_end;

  rr_priority_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .sel    (pick_id)
  );

  assign grant_oh    = NUM_REQ'(1) << grant_id;
  assign owner_valid = |(bus.req_valid & grant_oh);
  assign owner_last  = |(bus.req_last & grant_oh);

  // Data mux follows grant_id in every state, so reset presents slice 0.
  assign bus.wdata    = DATA_WIDTH'(bus.req_data >> (int'(grant_id) * DATA_WIDTH));
  assign bus.grant_id = grant_id;
  assign bus.busy     = (state == BURST);

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_id_nxt  = grant_id;
    beat_cnt_nxt  = beat_cnt;
    accept        = 1'b0;
    burst_end     = 1'b0;
    bus.winc      = 1'b0;
    bus.req_ready = '0;

    case (state)
      IDLE: begin
        // Arbitration cycle only; no beat is written here.
        if (pick_found) begin
          grant_id_nxt = pick_id;
          beat_cnt_nxt = '0;
          state_nxt    = BURST;
        end
      end
      BURST: begin
        // Owner dropping valid or wfull simply holds everything in place.
        accept   = owner_valid && !bus.wfull;
        bus.winc = accept;
        if (accept) begin
          bus.req_ready = grant_oh;
          burst_end     = owner_last || (beat_cnt == CNT_WIDTH'(MAX_BURST - 1));
          if (burst_end) begin
            state_nxt    = IDLE;
            rr_ptr_nxt   = ID_WIDTH'(rr_next(32'(grant_id), NUM_REQ));
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_id <= grant_id_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
// Purpose: directed stimulus with hand-computed expectations for the
//          write-port arbiter (3 requesters, 8-bit data, MAX_BURST=4).
// Ports:   none (top-level bench).
module tb_fifo_wr_arbiter;

  localparam int NR = 3;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IW = 2;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB),
    .ID_WIDTH   (IW)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic set_req(input logic [NR-1:0] v, input logic [NR-1:0] l);
    bus.req_valid = v;
    bus.req_last  = l;
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] d);
    bus.req_data[i*DW +: DW] = d;
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.wfull     = 1'b0;
    wrst_n        = 1'b0;
    tick();
    tick();
    wrst_n = 1'b1;
    #1;
  endtask

  initial begin
    int exp_g[4];
    exp_g = '{0, 1, 2, 0};

    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = 24'hC3B25A;
    bus.wfull     = 1'b0;

    // Reset values
    #1 wrst_n = 1'b0;
    tick();
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_winc", bus.winc, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_grant", bus.grant_id, 0);
    check("rst_wdata", bus.wdata, 8'h5A);
    check("rst_rr_ptr", dut.rr_ptr, 0);
    check("rst_beat_cnt", dut.beat_cnt, 0);
    wrst_n = 1'b1;
    #1;

    // Single requester 1, three beats, last on beat 3
    set_data(1, 8'hA1);
    set_req(3'b010, 3'b000);
    check("t1_idle_busy", bus.busy, 0);
    check("t1_idle_winc", bus.winc, 0);
    tick();
    check("t1_grant", bus.grant_id, 1);
    check("t1_busy", bus.busy, 1);
    check("t1_b1_winc", bus.winc, 1);
    check("t1_b1_wdata", bus.wdata, 8'hA1);
    check("t1_b1_ready", bus.req_ready, 3'b010);
    tick();
    set_data(1, 8'hA2);
    check("t1_b2_winc", bus.winc, 1);
    check("t1_b2_wdata", bus.wdata, 8'hA2);
    tick();
    set_data(1, 8'hA3);
    set_req(3'b010, 3'b010);
    check("t1_b3_winc", bus.winc, 1);
    check("t1_b3_wdata", bus.wdata, 8'hA3);
    check("t1_b3_ready", bus.req_ready, 3'b010);
    tick();
    set_req(3'b000, 3'b000);
    check("t1_end_busy", bus.busy, 0);
    check("t1_end_winc", bus.winc, 0);
    check("t1_end_rr_ptr", dut.rr_ptr, 2);

    // All three valid, no last: MAX_BURST-limited rotation 0,1,2,0
    do_reset();
    bus.req_data = 24'h302010;
    set_req(3'b111, 3'b000);
    for (int g = 0; g < 4; g++) begin
      check($sformatf("t2_g%0d_idle_busy", g), bus.busy, 0);
      check($sformatf("t2_g%0d_idle_winc", g), bus.winc, 0);
      tick();
      for (int b = 0; b < MB; b++) begin
        check($sformatf("t2_g%0d_b%0d_grant", g, b), bus.grant_id, exp_g[g]);
        check($sformatf("t2_g%0d_b%0d_winc", g, b), bus.winc, 1);
        check($sformatf("t2_g%0d_b%0d_wdata", g, b), bus.wdata, 32'h10 * (exp_g[g] + 1));
        tick();
      end
    end
    set_req(3'b000, 3'b000);
    check("t2_end_busy", bus.busy, 0);

    // wfull stall for 5 cycles after beat 2 of requester 0
    do_reset();
    set_data(0, 8'h41);
    set_req(3'b001, 3'b000);
    tick();
    check("t3_b1_winc", bus.winc, 1);
    tick();
    set_data(0, 8'h42);
    check("t3_b2_winc", bus.winc, 1);
    tick();
    bus.wfull = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t3_full%0d_winc", c), bus.winc, 0);
      check($sformatf("t3_full%0d_ready", c), bus.req_ready, 0);
      check($sformatf("t3_full%0d_beat_cnt", c), dut.beat_cnt, 2);
      check($sformatf("t3_full%0d_busy", c), bus.busy, 1);
      tick();
    end
    bus.wfull = 1'b0;
    set_data(0, 8'h43);
    check("t3_b3_winc", bus.winc, 1);
    check("t3_b3_wdata", bus.wdata, 8'h43);
    check("t3_b3_beat_cnt", dut.beat_cnt, 2);
    tick();
    check("t3_b4_winc", bus.winc, 1);
    check("t3_b4_beat_cnt", dut.beat_cnt, 3);
    tick();
    set_req(3'b000, 3'b000);
    check("t3_end_busy", bus.busy, 0);

    // Requester 2 drops valid mid-burst while requester 0 waits
    do_reset();
    set_data(2, 8'h77);
    set_data(0, 8'h07);
    set_req(3'b100, 3'b000);
    tick();
    check("t4_grant", bus.grant_id, 2);
    check("t4_b1_winc", bus.winc, 1);
    tick();
    set_req(3'b001, 3'b000);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("t4_gap%0d_grant", c), bus.grant_id, 2);
      check($sformatf("t4_gap%0d_winc", c), bus.winc, 0);
      check($sformatf("t4_gap%0d_ready", c), bus.req_ready, 0);
      check($sformatf("t4_gap%0d_busy", c), bus.busy, 1);
      tick();
    end
    set_req(3'b101, 3'b100);
    check("t4_last_winc", bus.winc, 1);
    check("t4_last_ready", bus.req_ready, 3'b100);
    check("t4_last_wdata", bus.wdata, 8'h77);
    tick();
    check("t4_idle_busy", bus.busy, 0);
    tick();
    check("t4_next_grant", bus.grant_id, 0);
    check("t4_next_ready", bus.req_ready, 3'b001);
    check("t4_next_wdata", bus.wdata, 8'h07);
    set_req(3'b001, 3'b001);
    tick();
    set_req(3'b000, 3'b000);

    // Asynchronous reset during beat 2 of requester 1
    do_reset();
    set_req(3'b010, 3'b000);
    tick();
    tick();
    check("t5_pre_winc", bus.winc, 1);
    wrst_n = 1'b0;
    #1;
    check("t5_rst_winc", bus.winc, 0);
    check("t5_rst_ready", bus.req_ready, 0);
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_rr_ptr", dut.rr_ptr, 0);
    set_req(3'b011, 3'b000);
    tick();
    wrst_n = 1'b1;
    #1;
    check("t5_rel_busy", bus.busy, 0);
    tick();
    check("t5_grant", bus.grant_id, 0);
    check("t5_busy", bus.busy, 1);

    // Requester 0 single-beat burst, then requester 1 wins
    set_req(3'b011, 3'b001);
    check("t6_winc", bus.winc, 1);
    check("t6_ready", bus.req_ready, 3'b001);
    tick();
    check("t6_idle_busy", bus.busy, 0);
    check("t6_idle_winc", bus.winc, 0);
    check("t6_rr_ptr", dut.rr_ptr, 1);
    tick();
    check("t6_grant", bus.grant_id, 1);
    check("t6_busy", bus.busy, 1);
    check("t6_ready1", bus.req_ready, 3'b010);
    set_req(3'b000, 3'b000);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
